// File: rtl/cpu_defs.sv
// Shared CPU definitions: bridge FSM encoding, kseg window bounds and the
// virtual-to-physical address helper used by both the data and fetch paths.
package cpu_defs;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // kseg0/kseg1 occupy the top-nibble window [KSEG_LO, KSEG_HI)
    localparam logic [3:0] KSEG_LO = 4'h8;
    localparam logic [3:0] KSEG_HI = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_e;

    // kseg0/kseg1 drop to the low 512 MiB; kuseg/kseg2/kseg3 pass through
    function automatic logic [ADDR_W-1:0] virt2phys(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] phys_s;
        if ((addr[ADDR_W-1 -: 4] >= KSEG_LO) && (addr[ADDR_W-1 -: 4] < KSEG_HI)) begin
            phys_s = {3'b000, addr[ADDR_W-4:0]};
        end else begin
            phys_s = addr;
        end
        return phys_s;
    endfunction

endpackage

// File: rtl/data_sram_bridge_if.sv
// Data-side bundle: the pipeline's SRAM-style port plus the req/addr_ok/data_ok
// memory bus. The bridge takes the slave view; the core/memory model the master view.
interface data_sram_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              cpu_req;
    logic              cpu_wr;
    logic [STRB_W-1:0] cpu_wstrb;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;

    logic              mem_req;
    logic              mem_wr;
    logic [STRB_W-1:0] mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_wstrb, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_wstrb, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

endinterface

// File: rtl/data_sram_bridge.sv
// Single-outstanding bridge from the MEM-stage SRAM port to a variable-latency
// req/addr_ok/data_ok bus. Each access is registered (address already mapped to
// physical), issued once, and the pipeline is stalled until the response returns.
module data_sram_bridge
    import cpu_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    data_sram_bridge_if.slave bus
);

    localparam int STRB_W = DATA_W / 8;

    bridge_state_e     state_r;
    bridge_state_e     state_nxt_s;
    logic              resp_s;
    logic              accept_s;
    logic              flush_r;
    logic              wr_r;
    logic [STRB_W-1:0] wstrb_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;

    assign accept_s = (state_r == ST_IDLE) && bus.cpu_req;

    // Next-state logic; resp_s marks the cycle the response is taken
    always_comb begin
        state_nxt_s = state_r;
        resp_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // data_ok without addr_ok is a protocol error and is ignored
                if (bus.mem_addr_ok && bus.mem_data_ok) begin
                    state_nxt_s = ST_DONE;
                    resp_s      = 1'b1;
                end else if (bus.mem_addr_ok) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.mem_data_ok) begin
                    state_nxt_s = ST_DONE;
                    resp_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request register: captured once on accept, stable for the whole transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_r    <= 1'b0;
            wstrb_r <= {STRB_W{1'b0}};
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            wr_r    <= bus.cpu_wr;
            wstrb_r <= bus.cpu_wr ? bus.cpu_wstrb : {STRB_W{1'b0}};
            addr_r  <= virt2phys(bus.cpu_addr);
            wdata_r <= bus.cpu_wdata;
        end
    end

    // Flush flag: remembers that the pipeline withdrew the access mid-flight
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_r <= 1'b0;
        end else if (accept_s) begin
            flush_r <= 1'b0;
        end else if ((state_r != ST_IDLE) && !bus.cpu_req) begin
            flush_r <= 1'b1;
        end
    end

    // Load data register: only a live (unflushed) load updates it
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (resp_s && !wr_r && bus.cpu_req && !flush_r) begin
            rdata_r <= bus.mem_rdata;
        end
    end

    assign bus.mem_req   = (state_r == ST_REQ);
    assign bus.mem_wr    = wr_r;
    assign bus.mem_wstrb = wstrb_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    // Combinational so that a brand-new request stalls in its very first cycle
    assign bus.cpu_stall = bus.cpu_req && (state_r != ST_DONE);
    assign bus.cpu_rdata = rdata_r;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: a table of single transactions run
// back-to-back, plus hand-written reset-in-WAIT and flush sequences.
module tb_data_sram_bridge;
    import cpu_defs::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_sram_bridge_if bus ();

    data_sram_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aok;        // cycle addr_ok is driven (cycle 0 = request)
        int          dok;        // cycle data_ok is driven
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        int          exp_done;   // cycle in which cpu_stall is low
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered #1 after a rising edge; leaves #1 after the edge that ends DONE
    task automatic run_txn(input vec_t v, input string tag);
        int c;
        bit done;
        bus.cpu_req   = 1'b1;
        bus.cpu_wr    = v.wr;
        bus.cpu_wstrb = v.wstrb;
        bus.cpu_addr  = v.addr;
        bus.cpu_wdata = v.wdata;
        c    = 0;
        done = 1'b0;
        while (!done && c < 20) begin
            bus.mem_addr_ok = (c == v.aok);
            bus.mem_data_ok = (c == v.dok);
            bus.mem_rdata   = (c == v.dok) ? v.rdata : 32'h0000_0000;
            @(negedge clk);
            if (c == 0) begin
                chk({tag, " req_first"}, 32'(bus.mem_req), 32'd0);
                chk({tag, " stall_first"}, 32'(bus.cpu_stall), 32'd1);
            end else if (c <= v.aok) begin
                chk({tag, " req_held"}, 32'(bus.mem_req), 32'd1);
                chk({tag, " addr"}, bus.mem_addr, v.exp_addr);
                if (c == 1) begin
                    chk({tag, " wstrb"}, 32'(bus.mem_wstrb), 32'(v.exp_wstrb));
                    chk({tag, " wr"}, 32'(bus.mem_wr), 32'(v.wr));
                    chk({tag, " wdata"}, bus.mem_wdata, v.wdata);
                end
            end else begin
                chk({tag, " req_low"}, 32'(bus.mem_req), 32'd0);
            end
            if (!bus.cpu_stall) begin
                done = 1'b1;
                chk({tag, " done_cycle"}, 32'(c), 32'(v.exp_done));
                chk({tag, " rdata"}, bus.cpu_rdata, v.exp_rdata);
            end
            @(posedge clk);
            #1;
            c++;
        end
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: stall still high after %0d cycles", tag, c);
        end
    endtask

    initial begin
        vec_t v;
        // wr wstrb addr wdata aok dok rdata exp_addr exp_wstrb exp_done exp_rdata
        vecs[0] = '{1'b0, 4'hF,    32'h8000_1000, 32'h0000_0000, 1, 3, 32'hDEAD_BEEF,
                    32'h0000_1000, 4'h0,    4, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 4'b0011, 32'hBFC0_0010, 32'h1234_5678, 1, 1, 32'hFFFF_FFFF,
                    32'h1FC0_0010, 4'b0011, 2, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 4'h0,    32'h0040_0000, 32'h0000_0000, 6, 7, 32'h0BAD_F00D,
                    32'h0040_0000, 4'h0,    8, 32'h0BAD_F00D};
        vecs[3] = '{1'b0, 4'h0,    32'hA000_0004, 32'h0000_0000, 1, 2, 32'h1111_2222,
                    32'h0000_0004, 4'h0,    3, 32'h1111_2222};
        vecs[4] = '{1'b0, 4'h0,    32'h9FFF_FFFC, 32'h0000_0000, 1, 1, 32'h3333_4444,
                    32'h1FFF_FFFC, 4'h0,    2, 32'h3333_4444};
        vecs[5] = '{1'b0, 4'h0,    32'hC000_0000, 32'h0000_0000, 2, 4, 32'h5555_6666,
                    32'hC000_0000, 4'h0,    5, 32'h5555_6666};
        vecs[6] = '{1'b0, 4'h0,    32'h7FFF_FFF0, 32'h0000_0000, 1, 1, 32'h7777_8888,
                    32'h7FFF_FFF0, 4'h0,    2, 32'h7777_8888};

        bus.cpu_req     = 1'b0;
        bus.cpu_wr      = 1'b0;
        bus.cpu_wstrb   = 4'h0;
        bus.cpu_addr    = 32'h0;
        bus.cpu_wdata   = 32'h0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'h0;
        reset           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst state", 32'(dut.state_r), 32'(ST_IDLE));
        chk("rst mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'h0);
        chk("rst mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("rst cpu_stall", 32'(bus.cpu_stall), 32'd0);
        @(posedge clk);
        #1;

        // Table: transactions issued back-to-back
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end
        bus.cpu_req = 1'b0;

        // Reset while in WAIT, stray data_ok one cycle later
        @(posedge clk);
        #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 32'h8000_2000;
        @(posedge clk);
        #1;
        bus.mem_addr_ok = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_addr_ok = 1'b0;
        @(negedge clk);
        chk("rstw in_wait", 32'(dut.state_r), 32'(ST_WAIT));
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        reset           = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("rstw state", 32'(dut.state_r), 32'(ST_IDLE));
        chk("rstw mem_req", 32'(bus.mem_req), 32'd0);
        chk("rstw cpu_rdata", bus.cpu_rdata, 32'h0);
        @(posedge clk);
        #1;
        bus.mem_data_ok = 1'b0;
        @(negedge clk);
        chk("rstw stray state", 32'(dut.state_r), 32'(ST_IDLE));
        chk("rstw stray rdata", bus.cpu_rdata, 32'h0);
        @(posedge clk);
        #1;

        // Known rdata before the flush test
        v = '{1'b0, 4'h0, 32'h0000_0200, 32'h0, 1, 2, 32'h1357_9BDF,
              32'h0000_0200, 4'h0, 3, 32'h1357_9BDF};
        run_txn(v, "preflush");

        // Flush: cpu_req dropped while in WAIT
        bus.cpu_req  = 1'b1;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 32'h0000_0100;
        @(posedge clk);
        #1;
        bus.mem_addr_ok = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_addr_ok = 1'b0;
        bus.cpu_req     = 1'b0;
        @(negedge clk);
        chk("flush wait state", 32'(dut.state_r), 32'(ST_WAIT));
        chk("flush mem_req", 32'(bus.mem_req), 32'd0);
        @(posedge clk);
        #1;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        bus.mem_data_ok = 1'b0;
        @(negedge clk);
        chk("flush done state", 32'(dut.state_r), 32'(ST_DONE));
        chk("flush rdata kept", bus.cpu_rdata, 32'h1357_9BDF);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("flush idle state", 32'(dut.state_r), 32'(ST_IDLE));
        chk("flush rdata idle", bus.cpu_rdata, 32'h1357_9BDF);
        @(posedge clk);
        #1;

        // Normal load after the flush
        v = '{1'b0, 4'h0, 32'hB000_0040, 32'h0, 2, 3, 32'h2468_ACE0,
              32'h1000_0040, 4'h0, 4, 32'h2468_ACE0};
        run_txn(v, "postflush");
        bus.cpu_req = 1'b0;
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
